// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, colour-word field positions and the colour type
// used by the border output stage and its sync counter.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_BORDER_W = 8;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int RED_LSB   = 0;
    localparam int RED_MSB   = 3;
    localparam int GREEN_LSB = 4;
    localparam int GREEN_MSB = 7;
    localparam int BLUE_LSB  = 8;
    localparam int BLUE_MSB  = 11;

    typedef logic [11:0] color_t;

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-rate divider plus horizontal/vertical raster counters.
// pix_ce and frame_start are single-clock strobes in the system clock domain.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_pix_ce,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             w_pix_ce;
    logic             w_h_last;
    logic             w_v_last;

    assign w_pix_ce = (r_div == DIV_LAST);
    assign w_h_last = (r_hcount == H_LAST);
    assign w_v_last = (r_vcount == V_LAST);

    // Free-running divider; the last count is the pixel enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_div <= '0;
        else if (w_pix_ce)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    // Raster position: x wraps every line, y steps on each x wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_pix_ce) begin
            if (w_h_last) begin
                r_hcount <= '0;
                r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    assign o_pix_ce      = w_pix_ce;
    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_frame_start = w_pix_ce & w_h_last & w_v_last;

endmodule

// File: rtl/vga_border_out.sv
// VGA output stage: decodes sync and border/interior regions from the raster
// counters and registers RGB/sync once per pixel.
// Optional build macro COLOR_LATCH_EN: colours are latched once per frame on
// frame_start so a frame is never painted with two different colours.
module vga_border_out
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int BORDER_W = DEF_BORDER_W
) (
    input  logic             CLK_100MHz,
    input  logic             RST_n,
    input  logic [11:0]      border,
    input  logic [11:0]      interior,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BRD_LO   = CNT_W'(BORDER_W);
    localparam logic [CNT_W-1:0] H_BRD_HI = CNT_W'(H_ACTIVE - BORDER_W);
    localparam logic [CNT_W-1:0] V_BRD_HI = CNT_W'(V_ACTIVE - BORDER_W);

    logic             w_pix_ce;
    logic             w_frame_start;
    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_active;
    logic             w_in_border;
    logic             w_hs_n;
    logic             w_vs_n;
    color_t           w_border;
    color_t           w_interior;
    color_t           w_rgb_next;
    color_t           r_rgb;
    logic             r_hsync;
    logic             r_vsync;

    vga_sync_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_sync_counter (
        .i_clk         (CLK_100MHz),
        .i_rst_n       (RST_n),
        .o_pix_ce      (w_pix_ce),
        .o_hcount      (w_hcount),
        .o_vcount      (w_vcount),
        .o_frame_start (w_frame_start)
    );

    assign w_active    = (w_hcount < H_ACT_C) && (w_vcount < V_ACT_C);
    assign w_hs_n      = !((w_hcount >= HS_BEG) && (w_hcount < HS_END));
    assign w_vs_n      = !((w_vcount >= VS_BEG) && (w_vcount < VS_END));
    assign w_in_border = w_active &&
                         ((w_hcount < BRD_LO) || (w_hcount >= H_BRD_HI) ||
                          (w_vcount < BRD_LO) || (w_vcount >= V_BRD_HI));

`ifdef COLOR_LATCH_EN
    color_t r_border_sh;
    color_t r_interior_sh;

    // Colours are frozen at the frame wrap and held for the whole frame.
    always_ff @(posedge CLK_100MHz or negedge RST_n) begin
        if (!RST_n) begin
            r_border_sh   <= '0;
            r_interior_sh <= '0;
        end else if (w_frame_start) begin
            r_border_sh   <= border;
            r_interior_sh <= interior;
        end
    end

    assign w_border   = r_border_sh;
    assign w_interior = r_interior_sh;
`else
    assign w_border   = border;
    assign w_interior = interior;
`endif

    // Border has priority over interior; blanking outside the active area.
    always_comb begin
        w_rgb_next = '0;
        if (w_in_border)
            w_rgb_next = w_border;
        else if (w_active)
            w_rgb_next = w_interior;
    end

    // Output registers move once per pixel, one pixel behind the counters.
    always_ff @(posedge CLK_100MHz or negedge RST_n) begin
        if (!RST_n) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pix_ce) begin
            r_rgb   <= w_rgb_next;
            r_hsync <= w_hs_n;
            r_vsync <= w_vs_n;
        end
    end

    assign vga_r       = r_rgb[RED_MSB:RED_LSB];
    assign vga_g       = r_rgb[GREEN_MSB:GREEN_LSB];
    assign vga_b       = r_rgb[BLUE_MSB:BLUE_LSB];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hcount      = w_hcount;
    assign vcount      = w_vcount;
    assign frame_start = w_frame_start;

endmodule

// File: tb/tb_vga_border_out.sv
// Bench for vga_border_out using a shrunken raster (24x17 totals) so several
// whole frames fit in a short run. Reference model derives everything from the
// number of clock edges since reset release.
module tb_vga_border_out;

    localparam int D     = 4;
    localparam int HA    = 16;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 3;
    localparam int VA    = 12;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 2;
    localparam int BW    = 2;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int WAIT_BUDGET = 2 * FRAME * D + 16;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [11:0] borderC = 12'h000;
    logic [11:0] interiorC = 12'h000;
    logic [3:0]  vgaR, vgaG, vgaB;
    logic        hsyncO, vsyncO, frameStart;
    logic [9:0]  hcountO, vcountO;

    int vecCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    vga_border_out #(
        .CLK_DIV (D),  .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .BORDER_W (BW)
    ) dut (
        .CLK_100MHz  (clk),
        .RST_n       (rstN),
        .border      (borderC),
        .interior    (interiorC),
        .vga_r       (vgaR),
        .vga_g       (vgaG),
        .vga_b       (vgaB),
        .hsync       (hsyncO),
        .vsync       (vsyncO),
        .hcount      (hcountO),
        .vcount      (vcountO),
        .frame_start (frameStart)
    );

    // Colour of a raster position under the border/interior/blank rules.
    function automatic logic [11:0] paint(int h, int v, logic [11:0] bc, logic [11:0] ic);
        bit act;
        bit inB;
        act = (h < HA) && (v < VA);
        inB = act && ((h < BW) || (h >= HA - BW) || (v < BW) || (v >= VA - BW));
        if (inB) return bc;
        if (act) return ic;
        return 12'h000;
    endfunction

    // Reference model: n counts clock edges since release; a pixel loads every D-th edge.
    int unsigned n;
    logic [11:0] mRgb;
    logic        mHs, mVs;
    logic [11:0] mShB, mShI;
    int          mPc, mH, mV;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            n = 0; mRgb = 12'h000; mHs = 1'b1; mVs = 1'b1; mShB = 12'h000; mShI = 12'h000;
        end else begin
            if (n % D == D - 1) begin
                mPc = int'(n / D);
                mH  = mPc % HT;
                mV  = (mPc / HT) % VT;
`ifdef COLOR_LATCH_EN
                mRgb = paint(mH, mV, mShB, mShI);
                if (mPc % FRAME == FRAME - 1) begin
                    mShB = borderC;
                    mShI = interiorC;
                end
`else
                mRgb = paint(mH, mV, borderC, interiorC);
`endif
                mHs = !((mH >= HA + HF) && (mH < HA + HF + HS));
                mVs = !((mV >= VA + VF) && (mV < VA + VF + VS));
            end
            n++;
        end
    end

    typedef struct {
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t tbl[18];

    task automatic checkOutput(string name);
        int pc, eh, ev;
        bit efs;
        pc  = int'(n / D);
        eh  = pc % HT;
        ev  = (pc / HT) % VT;
        efs = (n % D == D - 1) && (pc % FRAME == FRAME - 1);
        vecCount++;
        if (hcountO !== 10'(eh) || vcountO !== 10'(ev) || frameStart !== efs ||
            {vgaB, vgaG, vgaR} !== mRgb || hsyncO !== mHs || vsyncO !== mVs) begin
            missCount++;
            $display("[TB] FAIL %s: got h=%0d v=%0d fs=%b rgb=%h hs=%b vs=%b, expected h=%0d v=%0d fs=%b rgb=%h hs=%b vs=%b",
                     name, hcountO, vcountO, frameStart, {vgaB, vgaG, vgaR}, hsyncO, vsyncO,
                     eh, ev, efs, mRgb, mHs, mVs);
        end
    endtask

    task automatic checkVal(string name, int actual, int expected);
        vecCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Wait until the counters arrive at (h,v), bounded by a cycle budget.
    task automatic waitArrive(int h, int v, output bit ok);
        bit prev;
        bit match;
        ok = 1'b0;
        prev = (hcountO == 10'(h)) && (vcountO == 10'(v));
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clk);
            match = (hcountO == 10'(h)) && (vcountO == 10'(v));
            if (match && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = match;
        end
        if (!ok) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL wait_pixel_%0d_%0d: counters never reached it, expected arrival", h, v);
        end
    endtask

    // Wait for the registered output of pixel (h,v) to be on the pins.
    task automatic waitPixelOut(int h, int v, output bit ok);
        waitArrive(h, v, ok);
        if (ok) begin
            repeat (D) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic waitFrameStart();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clk);
            if (frameStart) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL wait_frame_start: got no pulse, expected one");
        end
    endtask

    task automatic applyStimulus(int cycles, int changeOdds);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput("random");
            if ($urandom_range(changeOdds - 1) == 0) borderC = 12'($urandom);
            if ($urandom_range(changeOdds - 1) == 0) interiorC = 12'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int cnt;
        logic [11:0] expB;

        tbl[0]  = '{5, 0, 12'h7A1, 1'b1, 1'b1};
        tbl[1]  = '{5, 1, 12'h7A1, 1'b1, 1'b1};
        tbl[2]  = '{5, 2, 12'h222, 1'b1, 1'b1};
        tbl[3]  = '{0, 5, 12'h7A1, 1'b1, 1'b1};
        tbl[4]  = '{1, 5, 12'h7A1, 1'b1, 1'b1};
        tbl[5]  = '{2, 5, 12'h222, 1'b1, 1'b1};
        tbl[6]  = '{13, 5, 12'h222, 1'b1, 1'b1};
        tbl[7]  = '{14, 5, 12'h7A1, 1'b1, 1'b1};
        tbl[8]  = '{15, 5, 12'h7A1, 1'b1, 1'b1};
        tbl[9]  = '{16, 5, 12'h000, 1'b1, 1'b1};
        tbl[10] = '{18, 5, 12'h000, 1'b0, 1'b1};
        tbl[11] = '{21, 5, 12'h000, 1'b1, 1'b1};
        tbl[12] = '{5, 9, 12'h222, 1'b1, 1'b1};
        tbl[13] = '{5, 10, 12'h7A1, 1'b1, 1'b1};
        tbl[14] = '{5, 11, 12'h7A1, 1'b1, 1'b1};
        tbl[15] = '{5, 12, 12'h000, 1'b1, 1'b1};
        tbl[16] = '{5, 13, 12'h000, 1'b1, 1'b0};
        tbl[17] = '{5, 15, 12'h000, 1'b1, 1'b1};

        // Reset state while held in reset.
        repeat (3) @(negedge clk);
        checkVal("reset_rgb", int'({vgaB, vgaG, vgaR}), 0);
        checkVal("reset_hsync", int'(hsyncO), 1);
        checkVal("reset_vsync", int'(vsyncO), 1);
        checkVal("reset_hcount", int'(hcountO), 0);
        checkVal("reset_frame_start", int'(frameStart), 0);

        // First pixel enable lands on the D-th edge after release.
        rstN = 1'b1;
        repeat (D - 1) @(posedge clk);
        @(negedge clk);
        checkVal("pre_first_ce_hcount", int'(hcountO), 0);
        @(posedge clk);
        @(negedge clk);
        checkVal("first_ce_hcount", int'(hcountO), 1);

        // Randomised colours against the model across several frames.
        applyStimulus(3 * FRAME * D, 40);

        // Table of hand-computed pixels.
        borderC = 12'h7A1;
        interiorC = 12'h222;
        waitFrameStart();
        for (int i = 0; i < 18; i++) begin
            waitPixelOut(tbl[i].h, tbl[i].v, ok);
            if (ok) begin
                vecCount++;
                if ({vgaB, vgaG, vgaR} !== tbl[i].rgb || hsyncO !== tbl[i].hs || vsyncO !== tbl[i].vs) begin
                    missCount++;
                    $display("[TB] FAIL table_%0d (%0d,%0d): got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             i, tbl[i].h, tbl[i].v, {vgaB, vgaG, vgaR}, hsyncO, vsyncO,
                             tbl[i].rgb, tbl[i].hs, tbl[i].vs);
                end
            end
        end

        // Sync and frame pulse duty over whole lines/frames.
        cnt = 0;
        for (int i = 0; i < HT * D; i++) begin
            @(negedge clk);
            if (!hsyncO) cnt++;
        end
        checkVal("hsync_low_clocks_per_line", cnt, HS * D);
        cnt = 0;
        for (int i = 0; i < FRAME * D; i++) begin
            @(negedge clk);
            if (!vsyncO) cnt++;
        end
        checkVal("vsync_low_clocks_per_frame", cnt, VS * HT * D);
        cnt = 0;
        for (int i = 0; i < FRAME * D; i++) begin
            @(negedge clk);
            if (frameStart) cnt++;
        end
        checkVal("frame_start_per_frame", cnt, 1);

        // Mid-frame border colour change.
        borderC = 12'h00F;
        waitFrameStart();
        waitArrive(0, 6, ok);
        borderC = 12'hF00;
        waitPixelOut(0, 7, ok);
`ifdef COLOR_LATCH_EN
        expB = 12'h00F;
`else
        expB = 12'hF00;
`endif
        if (ok) checkVal("colour_change_same_frame", int'({vgaB, vgaG, vgaR}), int'(expB));
        waitFrameStart();
        waitPixelOut(0, 7, ok);
        if (ok) checkVal("colour_change_next_frame", int'({vgaB, vgaG, vgaR}), 12'hF00);

        // Asynchronous reset in the middle of a frame.
        waitArrive(10, 6, ok);
        #2 rstN = 1'b0;
        #1;
        checkVal("midreset_rgb", int'({vgaB, vgaG, vgaR}), 0);
        checkVal("midreset_hsync", int'(hsyncO), 1);
        checkVal("midreset_vsync", int'(vsyncO), 1);
        checkVal("midreset_hcount", int'(hcountO), 0);
        checkVal("midreset_vcount", int'(vcountO), 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2 * FRAME * D, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
